// File: rtl/rmt_pkg.sv
// Shared RMT definitions: PHV width, AXIS segmentation helpers and the
// serializer FSM state encoding.
package rmt_pkg;

    localparam int PKT_VEC_WIDTH       = 1124;
    localparam int AXIS_DATA_WIDTH_DEF = 256;

    localparam logic [0:0] SER_IDLE = 1'b0;
    localparam logic [0:0] SER_SEND = 1'b1;

    function automatic int calc_num_seg(input int vec_w, input int data_w);
        return (vec_w + data_w - 1) / data_w;
    endfunction

    // Bytes carried by the final (possibly partial) segment of a frame.
    function automatic int calc_last_bytes(input int vec_w, input int data_w);
        int rem;
        rem = vec_w - (calc_num_seg(vec_w, data_w) - 1) * data_w;
        return (rem + 7) / 8;
    endfunction

    localparam int NUM_SEG_DEF = calc_num_seg(PKT_VEC_WIDTH, AXIS_DATA_WIDTH_DEF);

    localparam logic [AXIS_DATA_WIDTH_DEF/8-1:0] LAST_TKEEP_DEF =
        (AXIS_DATA_WIDTH_DEF/8)'((64'd1 << calc_last_bytes(PKT_VEC_WIDTH, AXIS_DATA_WIDTH_DEF)) - 64'd1);

endpackage

// File: rtl/phv_ser_buf.sv
// One PHV holding register with a valid flag; load wins over clear so a
// buffer can be refilled in the same cycle its previous frame drains.
module phv_ser_buf
    import rmt_pkg::*;
#(
    parameter int WIDTH = 1280
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            data_reg <= din;
        end
    end

    assign dout  = data_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/phv_axis_serializer.sv
// Serializes one PHV per handshake into an LSB-first multi-beat AXI4-Stream frame.
// Define PHV_SER_PINGPONG_EN for a second holding buffer (back-to-back frames).
module phv_axis_serializer #(
    parameter int PKT_VEC_WIDTH      = rmt_pkg::PKT_VEC_WIDTH,
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PKT_VEC_WIDTH-1:0]        phv_in,
    input  logic                            phv_in_valid,
    output logic                            phv_in_ready,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [31:0]                     frame_cnt
);
    import rmt_pkg::*;

    localparam int NUM_SEG    = rmt_pkg::calc_num_seg(PKT_VEC_WIDTH, C_AXIS_DATA_WIDTH);
    localparam int BUF_WIDTH  = NUM_SEG * C_AXIS_DATA_WIDTH;
    localparam int KEEP_WIDTH = C_AXIS_DATA_WIDTH / 8;
    localparam int LAST_BYTES = rmt_pkg::calc_last_bytes(PKT_VEC_WIDTH, C_AXIS_DATA_WIDTH);
    localparam int SEG_W      = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
`ifdef PHV_SER_PINGPONG_EN
    localparam int NUM_BUF    = 2;
`else
    localparam int NUM_BUF    = 1;
`endif
    localparam logic PINGPONG = (NUM_BUF > 1);

    logic [0:0]             state_reg;
    logic [0:0]             state_next;
    logic                   ready_reg;
    logic [SEG_W-1:0]       seg_idx_reg;
    logic [15:0]            seq_reg;
    logic [31:0]            frame_cnt_reg;
    logic                   wr_ptr_reg;
    logic                   rd_ptr_reg;

    logic                   send;
    logic                   accept;
    logic                   beat;
    logic                   last_seg;
    logic                   frame_done;

    logic [BUF_WIDTH-1:0]   phv_ext;
    logic [BUF_WIDTH-1:0]   buf_data [NUM_BUF];
    logic [NUM_BUF-1:0]     buf_load;
    logic [NUM_BUF-1:0]     buf_clear;
    logic [NUM_BUF-1:0]     buf_valid;
    logic [NUM_BUF-1:0]     buf_valid_next;
    logic [BUF_WIDTH-1:0]   rd_data;
    logic [C_AXIS_DATA_WIDTH-1:0] seg_data;
    logic [KEEP_WIDTH-1:0]  last_keep;

    assign send       = (state_reg == SER_SEND);
    assign accept     = phv_in_valid & ready_reg;
    assign beat       = send & m_axis_tready;
    assign last_seg   = (seg_idx_reg == SEG_W'(NUM_SEG - 1));
    assign frame_done = beat & last_seg;

    always_comb begin
        phv_ext = '0;
        phv_ext[PKT_VEC_WIDTH-1:0] = phv_in;
    end

    // Buffers fill in wr_ptr order and drain in rd_ptr order, so frames leave in acceptance order.
    generate
        for (genvar gi = 0; gi < NUM_BUF; gi++) begin : g_buf
            assign buf_load[gi]       = accept & (wr_ptr_reg == 1'(gi));
            assign buf_clear[gi]      = frame_done & (rd_ptr_reg == 1'(gi));
            assign buf_valid_next[gi] = buf_load[gi] | (buf_valid[gi] & ~buf_clear[gi]);

            phv_ser_buf #(
                .WIDTH (BUF_WIDTH)
            ) u_buf (
                .clk   (clk),
                .rst   (rst),
                .load  (buf_load[gi]),
                .clear (buf_clear[gi]),
                .din   (phv_ext),
                .dout  (buf_data[gi]),
                .valid (buf_valid[gi])
            );
        end

        for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_keep
            assign last_keep[gi] = (gi < LAST_BYTES);
        end
    endgenerate

    assign rd_data  = (PINGPONG && rd_ptr_reg) ? buf_data[NUM_BUF-1] : buf_data[0];
    assign seg_data = rd_data[int'(seg_idx_reg) * C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SER_IDLE: if (accept) state_next = SER_SEND;
            default:  if (frame_done && !(|buf_valid_next)) state_next = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= SER_IDLE;
            ready_reg     <= 1'b0;
            seg_idx_reg   <= '0;
            seq_reg       <= 16'd0;
            frame_cnt_reg <= 32'd0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            // Registered from next buffer occupancy only; tready never reaches phv_in_ready combinationally.
            ready_reg  <= ~&buf_valid_next;
            wr_ptr_reg <= wr_ptr_reg ^ (accept & PINGPONG);
            rd_ptr_reg <= rd_ptr_reg ^ (frame_done & PINGPONG);
            if (beat) begin
                seg_idx_reg <= last_seg ? '0 : seg_idx_reg + SEG_W'(1);
            end
            if (frame_done) begin
                seq_reg <= seq_reg + 16'd1;
                if (frame_cnt_reg != 32'hFFFF_FFFF) begin
                    frame_cnt_reg <= frame_cnt_reg + 32'd1;
                end
            end
        end
    end

    // Outputs are zero outside a frame and depend only on registers, so they hold under backpressure.
    always_comb begin
        m_axis_tvalid = send;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tlast  = 1'b0;
        if (send) begin
            m_axis_tdata       = seg_data;
            m_axis_tkeep       = last_seg ? last_keep : '1;
            m_axis_tuser[15:0] = seq_reg;
            m_axis_tlast       = last_seg;
        end
    end

    assign phv_in_ready = ready_reg;
    assign frame_cnt    = frame_cnt_reg;

endmodule

// File: tb/tb_phv_axis_serializer.sv
// Directed self-checking bench for phv_axis_serializer; builds with or
// without PHV_SER_PINGPONG_EN.
`timescale 1ns/1ps
module tb_phv_axis_serializer;

    localparam int PW   = 1124;
    localparam int DW   = 256;
    localparam int UW   = 128;
    localparam int KW   = DW / 8;
    localparam int NSEG = 5;
`ifdef PHV_SER_PINGPONG_EN
    localparam int GAP  = 1;
`else
    localparam int GAP  = 2;
`endif
    localparam int SPAN = 14 + 2 * (GAP - 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] phv_in = '0;
    logic          phv_in_valid = 1'b0;
    logic          phv_in_ready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic [31:0]   frame_cnt;

    phv_axis_serializer dut (
        .clk           (clk),
        .rst           (rst),
        .phv_in        (phv_in),
        .phv_in_valid  (phv_in_valid),
        .phv_in_ready  (phv_in_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
        int            stall;
        longint        cyc;
    } beat_t;

    beat_t   beat_q[$];
    int      tests_run = 0;
    int      tests_failed = 0;
    longint  cyc = 0;
    longint  acc_cyc = 0;
    bit      ready_mode = 1'b0;

    logic [PW-1:0] phv_arr [1000];
    logic [PW-1:0] p3 [3];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (ready_mode) m_axis_tready = 1'($urandom_range(0, 1));
    end

    // Monitor: samples at negedge what the next posedge will handshake.
    logic [DW-1:0]  prev_data;
    logic [161:0]   prev_ctrl;
    bit             stall_prev = 1'b0;
    int             stall_cnt = 0;
    beat_t          mb;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            stall_cnt  = 0;
        end else begin
            if (stall_prev) begin
                check("hold_data", m_axis_tdata, prev_data);
                check("hold_ctrl", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser}, prev_ctrl);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                mb.data  = m_axis_tdata;
                mb.keep  = m_axis_tkeep;
                mb.user  = m_axis_tuser;
                mb.last  = m_axis_tlast;
                mb.stall = stall_cnt;
                mb.cyc   = cyc;
                beat_q.push_back(mb);
                stall_cnt = 0;
            end else if (m_axis_tvalid) begin
                stall_cnt++;
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_ctrl  = {1'b1, m_axis_tlast, m_axis_tkeep, m_axis_tuser};
        end
    end

    function automatic logic [PW-1:0] rand_phv();
        logic [36*32-1:0] t;
        for (int j = 0; j < 36; j++) t[j*32 +: 32] = $urandom();
        return t[PW-1:0];
    endfunction

    task automatic send_phv(input logic [PW-1:0] phv);
        bit done;
        done = 1'b0;
        phv_in       = phv;
        phv_in_valid = 1'b1;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (phv_in_ready) begin
                done    = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        phv_in_valid = 1'b0;
        if (!done) check("accept_timeout", done, 1);
    endtask

    task automatic wait_beats(input int n, input int budget);
        int i;
        i = 0;
        while (beat_q.size() < n && i < budget) begin
            @(posedge clk);
            #3;
            i++;
        end
        if (beat_q.size() < n) check("wait_beats", beat_q.size(), n);
    endtask

    task automatic check_frame(input string tag, input logic [PW-1:0] phv, input logic [15:0] seq);
        logic [NSEG*DW-1:0] ext;
        beat_t b;
        ext = '0;
        ext[PW-1:0] = phv;
        for (int i = 0; i < NSEG; i++) begin
            if (beat_q.size() == 0) begin
                check({tag, "_missing"}, beat_q.size(), NSEG - i);
                return;
            end
            b = beat_q.pop_front();
            check($sformatf("%s_data%0d", tag, i), b.data, ext[i*DW +: DW]);
            check($sformatf("%s_keep%0d", tag, i), b.keep, (i == NSEG - 1) ? 32'h0000_1FFF : 32'hFFFF_FFFF);
            check($sformatf("%s_user%0d", tag, i), b.user, {112'd0, seq});
            check($sformatf("%s_last%0d", tag, i), b.last, (i == NSEG - 1));
        end
        $display("[TB] %s frame seq=%04h %0d beats checked", tag, seq, NSEG);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        phv_in_valid  = 1'b0;
        ready_mode    = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("rst_ready", phv_in_ready, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_ctrl", {m_axis_tlast, m_axis_tkeep, m_axis_tuser}, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("ready_low_at_deassert", phv_in_ready, 0);
        @(posedge clk);
        #1;
        check("ready_after_rst", phv_in_ready, 1);
        beat_q.delete();
    endtask

    logic [PW-1:0] p1, p2, p4a, p4b, p5a, p5b;

    initial begin
        // 1: alternating pattern, one frame, tready held high
        do_reset();
        for (int k = 0; k < PW; k++) p1[k] = 1'(k % 2);
        send_phv(p1);
        wait_beats(NSEG, 100);
        check("t1_b0_data", beat_q[0].data, {64{4'hA}});
        check("t1_b0_keep", beat_q[0].keep, 32'hFFFF_FFFF);
        check("t1_b0_last", beat_q[0].last, 0);
        check("t1_latency", beat_q[0].cyc - acc_cyc, 1);
        check("t1_b4_data", beat_q[4].data, {156'd0, {25{4'hA}}});
        check("t1_b4_keep", beat_q[4].keep, 32'h0000_1FFF);
        check("t1_b4_last", beat_q[4].last, 1);
        check("t1_b4_seq", beat_q[4].user[15:0], 16'h0000);
        check_frame("t1", p1, 16'h0000);
        check("t1_frame_cnt", frame_cnt, 1);

        // 2: three-cycle stall on beat 2
        do_reset();
        p2 = rand_phv();
        send_phv(p2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_axis_tready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        m_axis_tready = 1'b1;
        wait_beats(NSEG, 100);
        check("t2_b2_stall", beat_q[2].stall, 3);
        check_frame("t2", p2, 16'h0000);
        repeat (4) @(posedge clk);
        #1;
        check("t2_no_extra", beat_q.size(), 0);
        check("t2_frame_cnt", frame_cnt, 1);

        // 3: three PHVs back to back
        do_reset();
        for (int j = 0; j < 3; j++) p3[j] = rand_phv();
        for (int j = 0; j < 3; j++) send_phv(p3[j]);
        wait_beats(3 * NSEG, 200);
        check("t3_gap01", beat_q[5].cyc - beat_q[4].cyc, GAP);
        check("t3_gap12", beat_q[10].cyc - beat_q[9].cyc, GAP);
        check("t3_span", beat_q[14].cyc - beat_q[0].cyc, SPAN);
        for (int j = 0; j < 3; j++) check_frame("t3", p3[j], 16'(j));
        check("t3_frame_cnt", frame_cnt, 3);

        // 4: reset pulse after beat 1 handshake
        do_reset();
        p4a = rand_phv();
        p4b = rand_phv();
        send_phv(p4a);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t4_tvalid", m_axis_tvalid, 0);
        check("t4_frame_cnt", frame_cnt, 0);
        check("t4_partial_beats", beat_q.size(), 2);
        check("t4_partial_last", beat_q[0].last | beat_q[1].last, 0);
        beat_q.delete();
        send_phv(p4b);
        wait_beats(NSEG, 100);
        check_frame("t4", p4b, 16'h0000);
        check("t4_frame_cnt_after", frame_cnt, 1);

        // 5: sequence number wrap
        do_reset();
        force dut.seq_reg = 16'hFFFF;
        @(posedge clk); #1;
        release dut.seq_reg;
        p5a = rand_phv();
        p5b = rand_phv();
        send_phv(p5a);
        send_phv(p5b);
        wait_beats(2 * NSEG, 200);
        check_frame("t5a", p5a, 16'hFFFF);
        check_frame("t5b", p5b, 16'h0000);

        // 6: random tready and random valid gaps, 1000 frames
        do_reset();
        ready_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
            phv_arr[i] = rand_phv();
            send_phv(phv_arr[i]);
        end
        wait_beats(1000 * NSEG, 2000);
        ready_mode    = 1'b0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 1000; i++) check_frame("t6", phv_arr[i], 16'(i));
        check("t6_frame_cnt", frame_cnt, 1000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
